mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencer for the 8x8 multiply-accumulate unit. It computes one dot product of length N over two operand buffers per job.
- Per job it issues synchronous-read addresses to two 8-bit operand buffers, steers the returned operands onto the MAC a/b inputs, and drives the MAC count index 1..N so the first product clears the accumulator.
- After the last product it captures the 21-bit MAC result and presents it on a valid/ready output.

Parameters:
- MAX_LEN, 16, largest accepted job length (1..31; the count field is 5 bits).
- ADDR_W, 5, operand buffer address width (2^ADDR_W >= MAX_LEN).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- len  in  5  job length N, sampled with start
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse when start carries an illegal len
- rd_en  out  1  operand buffer read enable
- rd_addr  out  ADDR_W  operand index, shared by both buffers
- a_rdata  in  8  buffer A data, valid the cycle after rd_en
- b_rdata  in  8  buffer B data, valid the cycle after rd_en
- mac_a  out  8  MAC operand a
- mac_b  out  8  MAC operand b
- mac_count  out  5  MAC index; 1 on the first product
- mac_out  in  21  MAC accumulator output (registered)
- res_data  out  21  captured dot-product result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result

Behaviour:
- Reset, asynchronous: state=IDLE. busy, err, rd_en, res_valid = 0. rd_addr, mac_count, res_data = 0. Internal len and index registers = 0.
- Outside RUN, mac_a, mac_b and mac_count are forced to 0. The MAC therefore accumulates +0 and holds its value.
- States: IDLE -> FETCH -> RUN -> CAPTURE -> HOLD -> IDLE.
- IDLE:
  - start=1 with 1<=len<=MAX_LEN: latch N=len, go to FETCH.
  - start=1 with len=0 or len>MAX_LEN: pulse err for one cycle, stay IDLE.
- FETCH (1 cycle): rd_en=1, rd_addr=0. Next state is RUN with idx=1.
- RUN (N cycles, idx=1..N):
  - mac_a=a_rdata, mac_b=b_rdata, mac_count=idx.
  - rd_en=1 and rd_addr=idx only while idx<N. The final RUN cycle issues no read.
  - idx increments each cycle. On the idx=N cycle, next state is CAPTURE.
- CAPTURE (1 cycle): mac_out now holds the final sum. res_data<=mac_out; next state is HOLD.
- HOLD:
  - res_valid=1 and res_data stays stable until res_valid&res_ready at a rising edge.
  - On that edge, go to IDLE with res_valid=0 on the following cycle.
  - A start in the same cycle as the handshake is ignored (not latched); the earliest new start is accepted in IDLE.
- Latency: res_valid rises exactly N+2 cycles after the edge that accepted start. The buffers see exactly N reads, addresses 0..N-1 in order.
- Width: products and sums are unsigned. Max 255*255*31 = 2,015,775 < 2^21, so no overflow is possible and none is detected.
- start while busy: ignored, no err.
- rst asserted mid-job: immediate return to IDLE with reset values. No result is produced. The MAC's stale accumulator is harmless because the next job's idx=1 clears it.
- N=1: FETCH, one RUN cycle with count=1 and no further read, then CAPTURE.
- len and start are don't-care outside IDLE.

Test Plan:
- N=4, A=[1,2,3,4], B=[5,6,7,8], res_ready=1 -> res_data=70 and res_valid 6 cycles after start. mac_count sequence is 1,2,3,4; rd_addr is 0,1,2,3.
- N=1, A[0]=255, B[0]=255 -> res_data=65025 and res_valid 3 cycles after start. Exactly one rd_en pulse.
- N=16, all operands 255 -> res_data=1,040,400. Then hold res_ready=0 for 5 cycles -> res_valid and res_data remain stable; release -> IDLE the next cycle.
- Two back-to-back jobs: N=3 all-ones (result 3), then N=2 with A=[2,2], B=[3,3] -> results 3 then 12, showing count=1 clears the accumulator. A start asserted during job 1 is ignored.
- start with len=0, and with len=17 -> a one-cycle err pulse each, busy stays 0, no rd_en.
- Assert rst during RUN at idx=2 of an N=8 job -> all outputs return to 0 asynchronously. A following N=2 job with A=[1,1], B=[1,1] yields 2.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one length-N dot product through an 8x8 MAC and returns the result on valid/ready
//   clk, rst                  : clock, async active-high reset
//   start, len, busy, err     : job request, job length, busy flag, illegal-length pulse
//   rd_en, rd_addr            : shared read port to operand buffers A and B
//   a_rdata, b_rdata          : operand data, one cycle after rd_en
//   mac_a, mac_b, mac_count   : MAC operands and 1-based product index
//   mac_out                   : MAC accumulator
//   res_data, res_valid, res_ready : result handshake
module mac_seq_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        len,
  output logic              busy,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        a_rdata,
  input  logic [7:0]        b_rdata,
  output logic [7:0]        mac_a,
  output logic [7:0]        mac_b,
  output logic [4:0]        mac_count,
  input  logic [20:0]       mac_out,
  output logic [20:0]       res_data,
  output logic              res_valid,
  input  logic              res_ready
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, RUN = 3'd2, CAPTURE = 3'd3, HOLD = 3'd4;
  logic [2:0] state, nxt;
  logic [4:0] n, idx;
  logic ok, run, more;
  assign ok   = (len != 5'd0) && (len <= 5'(MAX_LEN));
  assign run  = state == RUN;
  assign more = idx < n;
  // the final RUN cycle issues no read: operand for idx=N was fetched on the idx=N-1 cycle
  always_comb begin
    nxt = state == IDLE    ? (start && ok ? FETCH : IDLE) :
          state == FETCH   ? RUN :
          run              ? (more ? RUN : CAPTURE) :
          state == CAPTURE ? HOLD :
          state == HOLD    ? (res_ready ? IDLE : HOLD) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      n        <= '0;
      idx      <= '0;
      res_data <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start && ok) n <= len;
      idx <= state == FETCH ? 5'd1 : run ? idx + 5'd1 : '0;
      if (state == CAPTURE) res_data <= mac_out;
    end
  end
  assign busy      = state != IDLE;
  assign err       = state == IDLE && start && !ok;
  assign rd_en     = state == FETCH || (run && more);
  assign rd_addr   = run && more ? ADDR_W'(idx) : '0;
  // forcing zero outside RUN makes the MAC accumulate +0, i.e. hold its value
  assign mac_a     = run ? a_rdata : '0;
  assign mac_b     = run ? b_rdata : '0;
  assign mac_count = run ? idx : '0;
  assign res_valid = state == HOLD;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: self-checking bench for mac_seq_ctrl with buffer and MAC models
module tb_mac_seq_ctrl;
  logic clk = 0, rst = 1, start = 0, res_ready = 0;
  logic [4:0] len = 0, mac_count;
  logic busy, err, rd_en, res_valid;
  logic [4:0] rd_addr;
  logic [7:0] a_rdata = 0, b_rdata = 0, mac_a, mac_b;
  logic [20:0] mac_out = 0, res_data;
  logic [7:0] A [32];
  logic [7:0] B [32];
  int checks = 0, errors = 0;
  int rd_q[$];
  int cnt_q[$];

  typedef struct {
    logic [4:0] len;
    logic       bad;
  } vec_t;
  vec_t tv [7];

  mac_seq_ctrl #(.MAX_LEN(16), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mac_a(mac_a), .mac_b(mac_b), .mac_count(mac_count), .mac_out(mac_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // synchronous-read operand buffers and a registered MAC (count==1 restarts the sum)
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= A[rd_addr];
      b_rdata <= B[rd_addr];
    end
    mac_out <= (mac_count == 5'd1 ? 21'd0 : mac_out) + 21'(mac_a) * 21'(mac_b);
  end

  // record read addresses and product indices; operands must match the buffer entry for that index
  always @(posedge clk) begin
    if (!rst && rd_en) rd_q.push_back(int'(rd_addr));
    if (!rst && mac_count != 0) begin
      cnt_q.push_back(int'(mac_count));
      chk("mac_a", 32'(mac_a), 32'(A[mac_count - 5'd1]));
      chk("mac_b", 32'(mac_b), 32'(B[mac_count - 5'd1]));
    end
  end

  task automatic fill(input int mode, input logic [7:0] va, input logic [7:0] vb);
    for (int i = 0; i < 32; i++) begin
      A[i] = mode ? 8'($urandom) : va;
      B[i] = mode ? 8'($urandom) : vb;
    end
  endtask

  // called just after a rising edge with the DUT idle
  task automatic run_job(input int n, input int hold, input bit noise);
    int cyc;
    logic [20:0] exp;
    exp = 0;
    for (int i = 0; i < n; i++) exp += 21'(A[i]) * 21'(B[i]);
    rd_q.delete();
    cnt_q.delete();
    start = 1;
    len = 5'(n);
    @(negedge clk);
    chk("accept_err", 32'(err), 0);
    @(posedge clk); #1;
    start = 0;
    cyc = 0;
    while (!res_valid && cyc < 80) begin
      if (noise) begin
        start = 1'($urandom);
        len = 5'($urandom);
      end
      @(negedge clk);
      chk("busy_run", 32'(busy), 1);
      chk("err_busy", 32'(err), 0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(n + 2));
    chk("res_data", 32'(res_data), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_data", 32'(res_data), 32'(exp));
    end
    res_ready = 1;
    if (noise) begin
      start = 1;
      len = 5'd1;
    end
    @(posedge clk); #1;
    res_ready = 0;
    chk("valid_drop", 32'(res_valid), 0);
    chk("idle_after", 32'(busy), 0);
    start = 0;
    chk("nreads", 32'(rd_q.size()), 32'(n));
    chk("ncounts", 32'(cnt_q.size()), 32'(n));
    for (int i = 0; i < n && i < rd_q.size() && i < cnt_q.size(); i++) begin
      chk("rd_addr_seq", 32'(rd_q[i]), 32'(i));
      chk("count_seq", 32'(cnt_q[i]), 32'(i + 1));
    end
  endtask

  initial begin
    tv[0] = '{5'd0, 1'b1};
    tv[1] = '{5'd17, 1'b1};
    tv[2] = '{5'd31, 1'b1};
    tv[3] = '{5'd1, 1'b0};
    tv[4] = '{5'd5, 1'b0};
    tv[5] = '{5'd16, 1'b0};
    tv[6] = '{5'd20, 1'b1};
    fill(0, 0, 0);
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_count", 32'(mac_count), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // N=4 dot product: 1*5+2*6+3*7+4*8 = 70
    for (int i = 0; i < 4; i++) begin
      A[i] = 8'(i + 1);
      B[i] = 8'(i + 5);
    end
    run_job(4, 0, 0);
    fill(0, 255, 255);
    run_job(1, 0, 0);
    run_job(16, 5, 0);
    // back-to-back: 3 then 12, with noise start during the first job
    fill(0, 1, 1);
    run_job(3, 0, 1);
    fill(0, 2, 3);
    run_job(2, 0, 0);

    // table of lengths: illegal ones pulse err, legal ones run to completion
    foreach (tv[k]) begin
      if (tv[k].bad) begin
        rd_q.delete();
        start = 1;
        len = tv[k].len;
        @(negedge clk);
        chk("err_pulse", 32'(err), 1);
        chk("err_busy0", 32'(busy), 0);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("err_cleared", 32'(err), 0);
        chk("err_idle", 32'(busy), 0);
        chk("err_no_read", 32'(rd_q.size()), 0);
        @(posedge clk); #1;
      end else begin
        fill(1, 0, 0);
        run_job(int'(tv[k].len), 1, 0);
      end
    end

    // reset in the middle of an N=8 job
    fill(1, 0, 0);
    start = 1;
    len = 5'd8;
    @(posedge clk); #1;
    start = 0;
    begin
      int w;
      w = 0;
      while (mac_count != 5'd2 && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("reached_idx2", 32'(mac_count), 2);
    end
    rst = 1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rd_en", 32'(rd_en), 0);
    chk("arst_rd_addr", 32'(rd_addr), 0);
    chk("arst_count", 32'(mac_count), 0);
    chk("arst_mac_a", 32'(mac_a), 0);
    chk("arst_res_valid", 32'(res_valid), 0);
    chk("arst_res_data", 32'(res_data), 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    fill(0, 1, 1);
    run_job(2, 0, 0);

    // randomized jobs against the arithmetic reference
    for (int r = 0; r < 25; r++) begin
      fill(1, 0, 0);
      run_job(int'($urandom_range(1, 16)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
